// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: buffers 16-word blocks, applies padding and
// drives the message schedule with a fixed 64-cycle busy window per block.
module sha256_msg_feeder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [1:0]  in_bytes,
    output logic        in_ready,
    input  logic        hash_ready,
    output logic [31:0] data,
    output logic        write_enable,
    output logic        inner_busy,
    output logic        block_start,
    output logic        msg_done
);

    typedef enum logic [2:0] {
        FILL, WAIT, LOAD, EXPAND, GAP, PADBLK
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  widx_q, widx_d;
    logic [3:0]  lidx_q, lidx_d;
    logic [2:0]  nb_q, nb_d;
    logic [60:0] bytes_q, bytes_d;
    logic        fin_q, fin_d;
    logic        spill_q, spill_d;
    logic [31:0] mem_q [16];

    logic [31:0] data_d;
    logic        we_d, busy_d, bs_d, done_d, wr_en;
    logic        accept;
    logic [2:0]  nin;
    logic [4:0]  pos;
    logic        need_spill;
    logic [63:0] len;
    logic [3:0]  wk;
    logic [31:0] bw, word;

    assign accept     = in_ready & in_valid;
    assign nin        = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
    assign pos        = (nb_q == 3'd4) ? {1'b0, lidx_q} + 5'd1 : {1'b0, lidx_q};
    assign need_spill = pos > 5'd13;
    assign len        = {bytes_q, 3'b000};
    assign wk         = (state_q == WAIT) ? 4'd0 : cnt_q[3:0] + 4'd1;
    assign bw         = mem_q[wk];

    // Block word wk, with padding applied to the final data block / spill block
    always_comb begin
        word = '0;
        if (spill_q) begin
            if (wk == 4'd0 && pos == 5'd16)
                word = 32'h8000_0000;
            else if (wk == 4'd14)
                word = len[63:32];
            else if (wk == 4'd15)
                word = len[31:0];
        end else if (!fin_q || wk < lidx_q) begin
            word = bw;
        end else if (wk == lidx_q) begin
            case (nb_q)
                3'd1:    word = {bw[31:24], 24'h80_0000};
                3'd2:    word = {bw[31:16], 16'h8000};
                3'd3:    word = {bw[31:8], 8'h80};
                default: word = bw;
            endcase
        end else if (nb_q == 3'd4 && {1'b0, wk} == pos && pos <= 5'd15) begin
            word = 32'h8000_0000;
        end else if (pos <= 5'd13 && wk == 4'd14) begin
            word = len[63:32];
        end else if (pos <= 5'd13 && wk == 4'd15) begin
            word = len[31:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        lidx_d  = lidx_q;
        nb_d    = nb_q;
        bytes_d = bytes_q;
        fin_d   = fin_q;
        spill_d = spill_q;
        data_d  = '0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        bs_d    = 1'b0;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    wr_en   = 1'b1;
                    widx_d  = widx_q + 4'd1;
                    bytes_d = bytes_q + {58'd0, in_last ? nin : 3'd4};
                    if (in_last) begin
                        fin_d  = 1'b1;
                        lidx_d = widx_q;
                        nb_d   = nin;
                    end
                    if (in_last || widx_q == 4'd15) begin
                        state_d = WAIT;
                        widx_d  = '0;
                    end
                end
            end
            WAIT: begin
                if (hash_ready) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    data_d  = word;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    bs_d    = 1'b1;
                end
            end
            LOAD: begin
                busy_d = 1'b1;
                if (cnt_q == 6'd15) begin
                    state_d = EXPAND;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 6'd1;
                    data_d = word;
                    we_d   = 1'b1;
                end
            end
            EXPAND: begin
                if (cnt_q == 6'd47) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    done_d  = fin_q & (spill_q | ~need_spill);
                end else begin
                    cnt_d  = cnt_q + 6'd1;
                    busy_d = 1'b1;
                end
            end
            GAP: begin
                if (fin_q && need_spill && !spill_q) begin
                    state_d = PADBLK;
                end else begin
                    state_d = FILL;
                    if (fin_q) begin
                        bytes_d = '0;
                        fin_d   = 1'b0;
                        spill_d = 1'b0;
                    end
                end
            end
            PADBLK: begin
                spill_d = 1'b1;
                state_d = WAIT;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            widx_q       <= '0;
            lidx_q       <= '0;
            nb_q         <= '0;
            bytes_q      <= '0;
            fin_q        <= 1'b0;
            spill_q      <= 1'b0;
            in_ready     <= 1'b0;
            data         <= '0;
            write_enable <= 1'b0;
            inner_busy   <= 1'b0;
            block_start  <= 1'b0;
            msg_done     <= 1'b0;
            for (int i = 0; i < 16; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            widx_q       <= widx_d;
            lidx_q       <= lidx_d;
            nb_q         <= nb_d;
            bytes_q      <= bytes_d;
            fin_q        <= fin_d;
            spill_q      <= spill_d;
            in_ready     <= (state_d == FILL);
            data         <= data_d;
            write_enable <= we_d;
            inner_busy   <= busy_d;
            block_start  <= bs_d;
            msg_done     <= done_d;
            if (wr_en) mem_q[widx_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Randomized bench for sha256_msg_feeder against a byte-level
// SHA-256 padding model.
module tb_sha256_msg_feeder;

    typedef byte unsigned bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  in_bytes = '0;
    logic        in_ready;
    logic        hash_ready = 1'b0;
    logic [31:0] data;
    logic        write_enable, inner_busy, block_start, msg_done;

    int n_chk = 0;
    int n_fail = 0;
    logic hr_rand = 1'b0;

    sha256_msg_feeder dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_bytes(in_bytes),
        .in_ready(in_ready), .hash_ready(hash_ready),
        .data(data), .write_enable(write_enable),
        .inner_busy(inner_busy), .block_start(block_start),
        .msg_done(msg_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (hr_rand) hash_ready = 1'($urandom_range(0, 1));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Standard SHA-256 padding of a byte string, split into 32-bit words
    function automatic wq_t pad_model(input bq_t m);
        bq_t p;
        wq_t w;
        longint unsigned bits;
        p = m;
        bits = longint'(m.size()) * 8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        for (int i = 0; i < p.size(); i += 4)
            w.push_back({p[i], p[i+1], p[i+2], p[i+3]});
        return w;
    endfunction

    task automatic drive(input bq_t m);
        int nw, idx, guard;
        logic [31:0] wv;
        nw = (m.size() + 3) / 4;
        idx = 0;
        guard = 0;
        while (idx < nw && guard < 5000) begin
            @(negedge clk);
            guard++;
            in_valid = ($urandom_range(0, 3) != 0);
            wv = '0;
            for (int b = 0; b < 4; b++)
                if (idx * 4 + b < m.size()) wv[31-8*b -: 8] = m[idx*4+b];
            in_data  = in_valid ? wv : $urandom;
            in_last  = (idx == nw - 1);
            in_bytes = 2'(m.size() % 4);
            if (in_valid && in_ready) idx++;
        end
        if (idx < nw) chk("drive_timeout", 64'(idx), 64'(nw));
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect(input wq_t exp, output int first_wait);
        int nblk, w;
        nblk = exp.size() / 16;
        first_wait = 0;
        for (int b = 0; b < nblk; b++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!block_start && w < 3000);
            if (b == 0) first_wait = w;
            if (!block_start) begin
                chk("block_timeout", 64'(b), 64'(nblk));
                return;
            end
            for (int i = 0; i < 64; i++) begin
                chk("busy", 64'(inner_busy), 64'd1);
                chk("we", 64'(write_enable), 64'(i < 16));
                chk("bs", 64'(block_start), 64'(i == 0));
                chk("done_early", 64'(msg_done), 64'd0);
                chk($sformatf("data b%0d w%0d", b, i), 64'(data),
                    64'(i < 16 ? exp[b*16+i] : 32'h0));
                @(negedge clk);
            end
            chk("gap_busy", 64'(inner_busy), 64'd0);
            chk("gap_data", 64'(data), 64'd0);
            chk("gap_done", 64'(msg_done), 64'(b == nblk - 1));
        end
    endtask

    task automatic run_msg(input bq_t m);
        wq_t exp;
        int fw;
        exp = pad_model(m);
        fork
            drive(m);
            collect(exp, fw);
        join
    endtask

    function automatic bq_t rand_msg(input int n);
        bq_t m;
        for (int i = 0; i < n; i++) m.push_back(8'($urandom));
        return m;
    endfunction

    initial begin
        bq_t m;
        wq_t exp;
        int fw, w;
        int lens[12] = '{1, 4, 52, 53, 55, 57, 59, 60, 61, 63, 65, 128};

        repeat (3) @(negedge clk);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_busy", 64'(inner_busy), 64'd0);
        chk("rst_bs", 64'(block_start), 64'd0);
        chk("rst_done", 64'(msg_done), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_rdy", 64'(in_ready), 64'd1);
        hash_ready = 1'b1;

        m = '{8'h61, 8'h62, 8'h63};
        exp = pad_model(m);
        chk("abc_w0", 64'(exp[0]), 64'h61626380);
        run_msg(m);

        run_msg(rand_msg(56));
        run_msg(rand_msg(64));

        // hash core stalled after FILL completes
        hash_ready = 1'b0;
        m = '{8'h61, 8'h62, 8'h63};
        drive(m);
        for (int i = 0; i < 20; i++) begin
            chk("hold_rdy", 64'(in_ready), 64'd0);
            chk("hold_busy", 64'(inner_busy), 64'd0);
            @(negedge clk);
        end
        hash_ready = 1'b1;
        collect(pad_model(m), fw);
        chk("hold_lat", 64'(fw), 64'd1);

        // reset in the middle of LOAD
        drive(m);
        w = 0;
        while (!block_start && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("rst_blk_seen", 64'(block_start), 64'd1);
        repeat (5) @(negedge clk);
        chk("mid_we", 64'(write_enable), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_data", 64'(data), 64'd0);
        chk("mid_we0", 64'(write_enable), 64'd0);
        chk("mid_busy", 64'(inner_busy), 64'd0);
        chk("mid_bs", 64'(block_start), 64'd0);
        chk("mid_done", 64'(msg_done), 64'd0);
        chk("mid_rdy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rel_rdy", 64'(in_ready), 64'd1);
        run_msg(m);

        // back-to-back: length counter must restart
        run_msg('{8'h11, 8'h22, 8'h33});
        m = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp = pad_model(m);
        chk("b2b_w1", 64'(exp[1]), 64'h55800000);
        chk("b2b_w15", 64'(exp[15]), 64'h28);
        run_msg(m);

        hr_rand = 1'b1;
        foreach (lens[i]) run_msg(rand_msg(lens[i]));
        for (int i = 0; i < 8; i++)
            run_msg(rand_msg($urandom_range(1, 140)));
        hr_rand = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_feeder.md
# sha256_msg_feeder

Producer side of the SHA-256 message-schedule word interface. It accepts a message as a stream of 32-bit big-endian words and buffers each 512-bit block. It applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit-length) and drives `data`/`write_enable`/`inner_busy` into the message schedule with the exact 64-cycle-per-block cadence that block requires. It sits between the host/DMA word stream and the message schedule plus hash core.

## Interface
- No parameters. Block size 16 words, round count 64 and length width 64 are fixed by SHA-256.
- `clk` input 1: single clock, all logic on posedge.
- `reset` input 1: synchronous, active-low. When low at a posedge, all state clears.
- `in_data` input 32: message word, first message byte in [31:24].
- `in_valid` input 1: `in_data` valid.
- `in_last` input 1: the current word is the final word of the message.
- `in_bytes` input 2: valid bytes in the final word. 2'd0 = 4, 2'd1..2'd3 = 1..3. Ignored unless `in_last`=1.
- `in_ready` output 1: word accepted on a cycle where `in_valid & in_ready`.
- `hash_ready` input 1: hash core can start a new block.
- `data` output 32: word to message schedule.
- `write_enable` output 1: `data` is a block word (first 16 cycles of a block).
- `inner_busy` output 1: schedule enable, high for exactly 64 consecutive cycles per block.
- `block_start` output 1: one-cycle pulse on the first busy cycle of each block.
- `msg_done` output 1: one-cycle pulse after the final block of a message.

## Operation
- States:
  - FILL: `in_ready`=1. Accept words into a 16x32 buffer at index `widx`. Add 4 per accepted word (or `in_bytes` on last) to a 61-bit byte count. Exit to WAIT when `widx` reaches 16 or a last word is accepted; record last index L and byte count n.
  - WAIT: `in_ready`=0. Go to LOAD on the cycle `hash_ready`=1.
  - LOAD: 16 cycles.
  - EXPAND: 48 cycles.
  - GAP: 1 cycle, all outputs 0. From GAP go to:
    - PADBLK if a spill block is pending;
    - FILL if the message is not finished;
    - FILL with `msg_done`=1 and the length cleared if this was the final block.
  - PADBLK: synthetic block with no input. Goes through WAIT, LOAD, EXPAND and GAP like a data block.
- Pad position p = L if n<4, else L+1. The length fits in the same block iff p ≤ 13. Otherwise a spill block is required.
- LOAD word k in a final data block:
  - k<L: buffer[k].
  - k=L: buffer word, bytes ≥n zeroed, with 0x80 in byte n if n<4. Examples: n=1 gives {b0,80,00,00}; n=4 gives the unchanged word.
  - k=L+1 when n=4 and p ≤ 15: 0x80000000.
  - k=14/15 when p ≤ 13: bit length [63:32]/[31:0] (bytes×8).
  - All other k: 0.
- Non-final blocks output buffer[0..15] unchanged.
- Spill block words:
  - word0 = 0x80000000 if p=16, else 0;
  - word14/15 = length;
  - all other words 0.
- Bit length = byte count << 3, 64 bits. Wrap beyond 2^61 bytes is unspecified.
- Messages of zero bytes are not supported. Minimum message is 1 byte.
- Words with `in_last`=0 always carry 4 bytes.

## Timing
- Reset values: `data`=0, `write_enable`=0, `inner_busy`=0, `block_start`=0, `msg_done`=0. State FILL, `widx`=0, byte count 0.
- `in_ready` is forced 0 while `reset` is low and is 1 from the first cycle after release.
- All outputs are registered.
- The cycle after a WAIT cycle with `hash_ready`=1 carries LOAD word 0 with `inner_busy`=1, `write_enable`=1 and `block_start`=1.
- Words 1..15 follow on consecutive cycles. They never stall.
- The next 48 cycles carry `inner_busy`=1, `write_enable`=0, `data`=0.
- The GAP cycle that follows has `inner_busy`=0. `msg_done` is asserted in that cycle for the final block.
- Minimum inter-block spacing is 1 GAP cycle plus FILL/WAIT occupancy.
- `in_ready`=1 for at most one accepted word per cycle. Handshakes with `in_valid`=0 are ignored.
- `reset` low mid-LOAD/EXPAND: outputs are 0 the next cycle, the block is aborted and no `msg_done` is generated.
- `hash_ready` is sampled only in WAIT. It is don't-care in other states.

## Test plan
- "abc": one word 0x61626300, `in_last`=1, `in_bytes`=3. Expect one block: word0 0x61626380, words 1..14 = 0, word15 0x00000018, 64 busy cycles, `msg_done` in the GAP cycle.
- 56-byte message (14 full words, last full, p=14). Expect block1 = 14 data words, word14 0x80000000, word15 0. Expect block2 = zeros with word14 0, word15 0x000001C0.
- 64-byte message (16 full words). Expect block1 = data only. Expect block2 word0 0x80000000, word15 0x00000200. `msg_done` only after block2.
- `hash_ready` held 0 for 20 cycles after FILL completes. Expect `in_ready`=0 and `inner_busy`=0 throughout; LOAD starts 1 cycle after `hash_ready` rises.
- `reset` driven low at LOAD word 5. Expect all outputs 0 the next cycle and `in_ready`=1 after release. A following "abc" message produces the correct single block.
- Two back-to-back messages, 3 bytes then 5 bytes (0x11223344, then 0x55 with `in_bytes`=1). Expect second-message word1 0x55800000 and word15 0x00000028, confirming the length counter restarts.
